mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/riscv_pkg.sv | 68 ++++++
 rtl/load_align.sv | 32 +++
 rtl/mem_stage.sv | 154 +++++++++++++++
 tb/tb_mem_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V constants and types for the memory stage.
//   - opcode / funct3 encodings seen on in_op = {funct3, opcode}
//   - access_size_e: byte/half/word/double access width
//   - mem_state_e:   memory-stage FSM states
//   - helpers: funct3 -> access size, alignment check, byte-enable mask
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // funct3 for loads; stores reuse the low four (SB/SH/SW/SD)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } access_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } mem_state_e;

    function automatic access_size_e size_of(input logic [2:0] funct3);
        access_size_e sz;
        case (funct3)
            F3_B, F3_BU: sz = SZ_B;
            F3_H, F3_HU: sz = SZ_H;
            F3_W, F3_WU: sz = SZ_W;
            F3_D:        sz = SZ_D;
            default:     sz = SZ_D;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input access_size_e sz, input logic [2:0] off);
        logic mis;
        case (sz)
            SZ_H:    mis = off[0];
            SZ_W:    mis = |off[1:0];
            SZ_D:    mis = |off;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte-enable mask for lane 0; the caller shifts it to the byte offset.
    function automatic logic [7:0] be_mask(input access_size_e sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: extracts a load value from a 64-bit memory doubleword.
//   rdata       in  64  doubleword returned by memory
//   offset      in  3   byte offset of the access inside the doubleword
//   size        in  2   access width (access_size_e)
//   is_unsigned in  1   zero-extend when set, sign-extend otherwise
//   data        out 64  right-justified, extended load value
module load_align
    import riscv_pkg::*;
(
    input  logic [63:0]  rdata,
    input  logic [2:0]   offset,
    input  access_size_e size,
    input  logic         is_unsigned,
    output logic [63:0]  data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            SZ_B:    data = is_unsigned ? {56'b0, shifted[7:0]}
                                        : {{56{shifted[7]}}, shifted[7:0]};
            SZ_H:    data = is_unsigned ? {48'b0, shifted[15:0]}
                                        : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    data = is_unsigned ? {32'b0, shifted[31:0]}
                                        : {{32{shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage between the ALU and register writeback.
// Non-memory results pass straight to writeback; loads and stores issue a
// single doubleword-aligned request and wait for dmem_ack.
//
//   clk, reset                      clock, async active-low reset
//   in_valid/in_op/in_data/in_addr  ALU result, {funct3,opcode}, data, store address
//   in_dest/in_wr_en/in_store/in_pc ALU destination, write enable, store flag, PC
//   flush                           kill the instruction presented this cycle
//   stall                           upstream hold (state != IDLE)
//   dmem_*                          data memory request / response
//   wb_*                            register writeback
//   misalign                        one-cycle pulse on a misaligned access
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | accepting; non-memory ops write back the following cycle
// ST_ISSUE | dmem request held stable until dmem_ack is sampled high
// ST_RESP  | load writeback cycle (wb_en registered on the ack edge)
module mem_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [9:0]  in_op,
    input  logic [63:0] in_data,
    input  logic [63:0] in_addr,
    input  logic [4:0]  in_dest,
    input  logic        in_wr_en,
    input  logic        in_store,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    output logic [7:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [63:0] dmem_rdata,
    output logic        wb_en,
    output logic [4:0]  wb_dest,
    output logic [63:0] wb_data,
    output logic [31:0] wb_pc,
    output logic        misalign
);

    mem_state_e   state;
    access_size_e ld_size;
    logic [2:0]   ld_off;
    logic         ld_unsigned;
    logic [4:0]   ld_dest;
    logic [31:0]  ld_pc;
    logic [63:0]  ld_value;

    logic [6:0]   opcode;
    logic [2:0]   funct3;
    logic         is_load;
    logic         is_store;
    logic [63:0]  eff_addr;
    access_size_e acc_size;
    logic         acc_mis;

    assign opcode   = in_op[6:0];
    assign funct3   = in_op[9:7];
    assign is_store = in_store;
    assign is_load  = (opcode == OPC_LOAD) && !in_store;
    // Loads carry their effective address on the data bus; stores use in_addr.
    assign eff_addr = is_store ? in_addr : in_data;
    assign acc_size = size_of(funct3);
    assign acc_mis  = is_misaligned(acc_size, eff_addr[2:0]);

    assign stall = (state != ST_IDLE);

    load_align u_load_align (
        .rdata       (dmem_rdata),
        .offset      (ld_off),
        .size        (ld_size),
        .is_unsigned (ld_unsigned),
        .data        (ld_value)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_wdata  <= '0;
            dmem_be     <= '0;
            wb_en       <= 1'b0;
            wb_dest     <= '0;
            wb_data     <= '0;
            wb_pc       <= '0;
            misalign    <= 1'b0;
            ld_size     <= SZ_B;
            ld_off      <= '0;
            ld_unsigned <= 1'b0;
            ld_dest     <= '0;
            ld_pc       <= '0;
        end else begin
            wb_en    <= 1'b0;
            misalign <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && !flush) begin
                        if (is_load || is_store) begin
                            if (acc_mis) begin
                                misalign <= 1'b1;
                            end else begin
                                state       <= ST_ISSUE;
                                dmem_req    <= 1'b1;
                                dmem_we     <= is_store;
                                dmem_addr   <= {eff_addr[63:3], 3'b000};
                                dmem_be     <= be_mask(acc_size) << eff_addr[2:0];
                                dmem_wdata  <= is_store ? (in_data << {eff_addr[2:0], 3'b000}) : '0;
                                ld_size     <= acc_size;
                                ld_off      <= eff_addr[2:0];
                                ld_unsigned <= funct3[2];
                                ld_dest     <= in_dest;
                                ld_pc       <= in_pc;
                            end
                        end else begin
                            wb_en   <= in_wr_en && (in_dest != 5'd0);
                            wb_dest <= in_dest;
                            wb_data <= in_data;
                            wb_pc   <= in_pc;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (!dmem_we) begin
                            // rdata is only valid with ack, so writeback is
                            // captured on this edge and shown during RESP.
                            state   <= ST_RESP;
                            wb_en   <= (ld_dest != 5'd0);
                            wb_dest <= ld_dest;
                            wb_data <= ld_value;
                            wb_pc   <= ld_pc;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import riscv_pkg::*;

    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [9:0]  in_op;
    logic [63:0] in_data;
    logic [63:0] in_addr;
    logic [4:0]  in_dest;
    logic        in_wr_en;
    logic        in_store;
    logic [31:0] in_pc;
    logic        flush;
    logic        stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [63:0] wb_data;
    logic [31:0] wb_pc;
    logic        misalign;

    mem_stage dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_op      (in_op),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .in_dest    (in_dest),
        .in_wr_en   (in_wr_en),
        .in_store   (in_store),
        .in_pc      (in_pc),
        .flush      (flush),
        .stall      (stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_be    (dmem_be),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .wb_en      (wb_en),
        .wb_dest    (wb_dest),
        .wb_data    (wb_data),
        .wb_pc      (wb_pc),
        .misalign   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  op;
        logic [63:0] data;
        logic [63:0] addr;
        logic [4:0]  dest;
        logic        wr_en;
        logic        store;
        logic [31:0] pc;
        int          delay;
        logic [63:0] rdata;
        logic        exp_mis;
        logic        exp_req;
        logic [63:0] exp_daddr;
        logic [7:0]  exp_be;
        logic [63:0] exp_wdata;
        logic        exp_wb;
        logic [63:0] exp_wbdata;
    } vec_t;

    typedef struct {
        logic [4:0]  dest;
        logic [63:0] data;
        logic [31:0] pc;
    } wb_t;

    int   checks = 0;
    int   errors = 0;
    wb_t  sb_q[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic [9:0] op, input logic [63:0] data, input logic [63:0] addr,
        input logic [4:0] dest, input logic wr_en, input logic store, input logic [31:0] pc,
        input int delay, input logic [63:0] rdata, input logic exp_mis, input logic exp_req,
        input logic [63:0] exp_daddr, input logic [7:0] exp_be, input logic [63:0] exp_wdata,
        input logic exp_wb, input logic [63:0] exp_wbdata);
        vec_t v;
        v.op = op; v.data = data; v.addr = addr; v.dest = dest; v.wr_en = wr_en;
        v.store = store; v.pc = pc; v.delay = delay; v.rdata = rdata;
        v.exp_mis = exp_mis; v.exp_req = exp_req; v.exp_daddr = exp_daddr;
        v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_wb = exp_wb;
        v.exp_wbdata = exp_wbdata;
        return v;
    endfunction

    // Writeback scoreboard: every observed wb_en pops one expected record.
    always @(negedge clk) begin
        if (reset === 1'b1 && wb_en === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got dest %0d data 0x%0h, expected no writeback",
                         wb_dest, wb_data);
            end else begin
                wb_t e;
                e = sb_q.pop_front();
                chk("wb_dest", 64'(wb_dest), 64'(e.dest));
                chk("wb_data", wb_data, e.data);
                chk("wb_pc", 64'(wb_pc), 64'(e.pc));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (stall !== 1'b0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idle", 64'(stall), 64'd0);
    endtask

    task automatic drive(input logic [9:0] op, input logic [63:0] data, input logic [63:0] addr,
                         input logic [4:0] dest, input logic wr_en, input logic store,
                         input logic [31:0] pc);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_addr  = addr;
        in_dest  = dest;
        in_wr_en = wr_en;
        in_store = store;
        in_pc    = pc;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d_", idx);
        wait_idle();
        if (v.exp_wb) sb_q.push_back('{v.dest, v.exp_wbdata, v.pc});
        drive(v.op, v.data, v.addr, v.dest, v.wr_en, v.store, v.pc);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({p, "misalign"}, 64'(misalign), 64'(v.exp_mis));
        chk({p, "req"}, 64'(dmem_req), 64'(v.exp_req));
        if (!v.exp_req) begin
            chk({p, "stall"}, 64'(stall), 64'd0);
            chk({p, "wb_en"}, 64'(wb_en), 64'(v.exp_wb));
            @(posedge clk); #1;
            chk({p, "misalign_off"}, 64'(misalign), 64'd0);
            chk({p, "wb_en_off"}, 64'(wb_en), 64'd0);
        end else begin
            chk({p, "we"}, 64'(dmem_we), 64'(v.store));
            chk({p, "daddr"}, dmem_addr, v.exp_daddr);
            chk({p, "be"}, 64'(dmem_be), 64'(v.exp_be));
            if (v.store) chk({p, "wdata"}, dmem_wdata, v.exp_wdata);
            for (int k = 1; k <= v.delay; k++) begin
                chk({p, "req_held"}, 64'(dmem_req), 64'd1);
                chk({p, "daddr_stable"}, dmem_addr, v.exp_daddr);
                chk({p, "wb_en_wait"}, 64'(wb_en), 64'd0);
                if (k == v.delay) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = v.rdata;
                end
                @(posedge clk); #1;
            end
            dmem_ack   = 1'b0;
            dmem_rdata = '0;
            chk({p, "req_drop"}, 64'(dmem_req), 64'd0);
            chk({p, "wb_lat"}, 64'(wb_en), 64'(v.exp_wb));
            chk({p, "resp_stall"}, 64'(stall), 64'(!v.store));
            @(posedge clk); #1;
            chk({p, "wb_once"}, 64'(wb_en), 64'd0);
            chk({p, "idle"}, 64'(stall), 64'd0);
        end
    endtask

    task automatic chk_all_zero(input string p);
        chk({p, "stall"}, 64'(stall), 64'd0);
        chk({p, "req"}, 64'(dmem_req), 64'd0);
        chk({p, "we"}, 64'(dmem_we), 64'd0);
        chk({p, "daddr"}, dmem_addr, 64'd0);
        chk({p, "wdata"}, dmem_wdata, 64'd0);
        chk({p, "be"}, 64'(dmem_be), 64'd0);
        chk({p, "wb_en"}, 64'(wb_en), 64'd0);
        chk({p, "wb_dest"}, 64'(wb_dest), 64'd0);
        chk({p, "wb_data"}, wb_data, 64'd0);
        chk({p, "wb_pc"}, 64'(wb_pc), 64'd0);
        chk({p, "misalign"}, 64'(misalign), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0; in_addr = '0;
        in_dest = '0; in_wr_en = 1'b0; in_store = 1'b0; in_pc = '0; flush = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = '0;

        //                op                 data                   addr     dst wr st  pc     dly rdata                  mis req daddr    be     wdata                  wb  wbdata
        vecs.push_back(mkv({3'b000, OPC_OPIMM}, 64'h1234,          64'h0,    5, 1, 0, 32'h100, 0, 64'h0,                0, 0, 64'h0,    8'h00, 64'h0,                1, 64'h1234));
        vecs.push_back(mkv({3'b000, OPC_OPIMM}, 64'h55,            64'h0,    0, 1, 0, 32'h104, 0, 64'h0,                0, 0, 64'h0,    8'h00, 64'h0,                0, 64'h0));
        vecs.push_back(mkv({3'b000, OPC_OP},    64'h77,            64'h0,    3, 0, 0, 32'h108, 0, 64'h0,                0, 0, 64'h0,    8'h00, 64'h0,                0, 64'h0));
        vecs.push_back(mkv({F3_W,  OPC_LOAD},   64'h1004,          64'h0,    7, 1, 0, 32'h10C, 3, 64'h8765432112345678, 0, 1, 64'h1000, 8'hF0, 64'h0,                1, 64'hFFFFFFFF87654321));
        vecs.push_back(mkv({F3_BU, OPC_LOAD},   64'h2007,          64'h0,    8, 1, 0, 32'h110, 1, 64'hAB00000000000000, 0, 1, 64'h2000, 8'h80, 64'h0,                1, 64'h00000000000000AB));
        vecs.push_back(mkv({F3_B,  OPC_LOAD},   64'h2007,          64'h0,    8, 1, 0, 32'h114, 2, 64'hAB00000000000000, 0, 1, 64'h2000, 8'h80, 64'h0,                1, 64'hFFFFFFFFFFFFFFAB));
        vecs.push_back(mkv({F3_H,  OPC_STORE},  64'h1234,          64'h3002, 0, 0, 1, 32'h118, 2, 64'h0,                0, 1, 64'h3000, 8'h0C, 64'h0000000012340000, 0, 64'h0));
        vecs.push_back(mkv({F3_W,  OPC_LOAD},   64'h1002,          64'h0,    7, 1, 0, 32'h11C, 0, 64'h0,                1, 0, 64'h0,    8'h00, 64'h0,                0, 64'h0));
        vecs.push_back(mkv({F3_D,  OPC_LOAD},   64'h4000,          64'h0,   10, 1, 0, 32'h120, 1, 64'h0123456789ABCDEF, 0, 1, 64'h4000, 8'hFF, 64'h0,                1, 64'h0123456789ABCDEF));
        vecs.push_back(mkv({F3_HU, OPC_LOAD},   64'h5006,          64'h0,   12, 1, 0, 32'h124, 1, 64'hBEEF000000000000, 0, 1, 64'h5000, 8'hC0, 64'h0,                1, 64'h000000000000BEEF));
        vecs.push_back(mkv({F3_H,  OPC_LOAD},   64'h5006,          64'h0,   13, 1, 0, 32'h128, 2, 64'hBEEF000000000000, 0, 1, 64'h5000, 8'hC0, 64'h0,                1, 64'hFFFFFFFFFFFFBEEF));
        vecs.push_back(mkv({F3_WU, OPC_LOAD},   64'h1004,          64'h0,   14, 1, 0, 32'h12C, 1, 64'h8765432112345678, 0, 1, 64'h1000, 8'hF0, 64'h0,                1, 64'h0000000087654321));
        vecs.push_back(mkv({F3_D,  OPC_STORE},  64'hDEADBEEFCAFEF00D, 64'h6000, 0, 0, 1, 32'h130, 1, 64'h0,          0, 1, 64'h6000, 8'hFF, 64'hDEADBEEFCAFEF00D, 0, 64'h0));
        vecs.push_back(mkv({F3_B,  OPC_STORE},  64'h5A,            64'h6005, 0, 0, 1, 32'h134, 3, 64'h0,                0, 1, 64'h6000, 8'h20, 64'h00005A0000000000, 0, 64'h0));
        vecs.push_back(mkv({F3_D,  OPC_LOAD},   64'h4004,          64'h0,   10, 1, 0, 32'h138, 0, 64'h0,                1, 0, 64'h0,    8'h00, 64'h0,                0, 64'h0));
        vecs.push_back(mkv({F3_W,  OPC_STORE},  64'h99,            64'h3006, 0, 0, 1, 32'h13C, 0, 64'h0,                1, 0, 64'h0,    8'h00, 64'h0,                0, 64'h0));
        vecs.push_back(mkv({F3_B,  OPC_LOAD},   64'h2001,          64'h0,    0, 1, 0, 32'h140, 1, 64'h000000000000AB00, 0, 1, 64'h2000, 8'h02, 64'h0,                0, 64'h0));
        vecs.push_back(mkv({F3_H,  OPC_LOAD},   64'h5001,          64'h0,   12, 1, 0, 32'h144, 0, 64'h0,                1, 0, 64'h0,    8'h00, 64'h0,                0, 64'h0));

        #12;
        chk_all_zero("reset_");
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset while a request is outstanding, then a stray ack after release.
        wait_idle();
        drive({F3_W, OPC_LOAD}, 64'h1000, 64'h0, 5'd9, 1'b1, 1'b0, 32'h300);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_issue_req", 64'(dmem_req), 64'd1);
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("rst_async_req", 64'(dmem_req), 64'd0);
        chk("rst_async_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        chk_all_zero("rst_late_ack_");
        @(posedge clk); #1;
        chk_all_zero("rst_after_");

        // Flush of the instruction held behind an outstanding LD.
        wait_idle();
        sb_q.push_back('{5'd11, 64'h0123456789ABCDEF, 32'h200});
        drive({F3_D, OPC_LOAD}, 64'h4000, 64'h0, 5'd11, 1'b1, 1'b0, 32'h200);
        @(posedge clk); #1;
        drive({3'b000, OPC_OPIMM}, 64'h55, 64'h0, 5'd5, 1'b1, 1'b0, 32'h204);
        flush = 1'b1;
        chk("flush_ld_req", 64'(dmem_req), 64'd1);
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        dmem_rdata = 64'h0123456789ABCDEF;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        chk("flush_ld_wb", 64'(wb_en), 64'd1);
        chk("flush_resp_stall", 64'(stall), 64'd1);
        @(posedge clk); #1;
        chk("flush_idle", 64'(stall), 64'd0);
        chk("flush_wb_once", 64'(wb_en), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_no_addi_wb", 64'(wb_en), 64'd0);
        chk("flush_no_req", 64'(dmem_req), 64'd0);
        @(posedge clk); #1;
        chk("flush_quiet", 64'(wb_en), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
